// File: rtl/mem_arbiter_seq.sv
// rtl/mem_arbiter_seq.sv - iCache/LSU arbiter and byte sequencer for the shared RAM/IO port.
// Optional write stall on a full IO FIFO: define MEMARB_IO_STALL_EN.
module mem_arbiter_seq #(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] IO_SEL       = 2'b11
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        ic_req,
  input  logic [31:0] ic_addr,
  output logic        ic_done,
  output logic [31:0] ic_data,
  input  logic        ls_req,
  input  logic        ls_rw,
  input  logic [1:0]  ls_width,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  output logic [7:0]  mem_dout,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic        owner_ic;
  logic [31:0] base;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic [2:0]  nbytes;
  logic [2:0]  cnt;
  logic [7:0]  starve_cnt;

  logic        grant_ic;
  logic        grant_ls;
  logic        stall_now;
  logic [1:0]  rd_idx;
  logic [31:0] rd_merge;

  function automatic logic [2:0] width_bytes(input logic [1:0] w);
    case (w)
      2'd0:    width_bytes = 3'd1;
      2'd1:    width_bytes = 3'd2;
      default: width_bytes = 3'd4;
    endcase
  endfunction

  assign grant_ic = ic_req && (!ls_req || (starve_cnt >= 8'(STARVE_LIMIT)));
  assign grant_ls = ls_req && !grant_ic;

`ifdef MEMARB_IO_STALL_EN
  assign stall_now = io_buffer_full &&
                     (((state == IDLE) ? ls_addr[17:16] : base[17:16]) == IO_SEL);
`else
  logic unused_io;
  assign unused_io = io_buffer_full;
  assign stall_now = 1'b0;
`endif

  // In READ, cnt counts cycles since grant; the byte arriving now belongs to cnt-1.
  assign rd_idx = cnt[1:0] - 2'd1;

  always_comb begin
    rd_merge = buf_q;
    rd_merge[{rd_idx, 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      owner_ic   <= 1'b0;
      base       <= '0;
      wdata_q    <= '0;
      buf_q      <= '0;
      nbytes     <= '0;
      cnt        <= '0;
      starve_cnt <= '0;
      ic_done    <= 1'b0;
      ic_data    <= '0;
      ls_done    <= 1'b0;
      ls_rdata   <= '0;
      mem_a      <= '0;
      mem_wr     <= 1'b0;
      mem_dout   <= '0;
    end else if (!rdy_in) begin
      mem_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          mem_wr <= 1'b0;
          if (grant_ic || grant_ls) begin
            buf_q    <= '0;
            cnt      <= '0;
            owner_ic <= grant_ic;
            if (grant_ic)
              starve_cnt <= '0;
            else if (ic_req && (starve_cnt < 8'(STARVE_LIMIT)))
              starve_cnt <= starve_cnt + 8'd1;
            if (grant_ic) begin
              base   <= ic_addr;
              nbytes <= 3'd4;
              mem_a  <= ic_addr;
              state  <= READ;
            end else begin
              base    <= ls_addr;
              nbytes  <= width_bytes(ls_width);
              wdata_q <= ls_wdata;
              if (!ls_rw) begin
                mem_a <= ls_addr;
                state <= READ;
              end else begin
                state <= WRITE;
                if (!stall_now) begin
                  mem_a    <= ls_addr;
                  mem_dout <= ls_wdata[7:0];
                  mem_wr   <= 1'b1;
                  cnt      <= 3'd1;
                end
              end
            end
          end
        end
        READ: begin
          if (cnt == nbytes) begin
            state <= DONE;
            if (owner_ic) begin
              ic_done <= 1'b1;
              ic_data <= rd_merge;
            end else begin
              ls_done  <= 1'b1;
              ls_rdata <= rd_merge;
            end
          end else begin
            if (cnt != 3'd0)
              buf_q[{rd_idx, 3'b000} +: 8] <= mem_din;
            if ((cnt + 3'd1) < nbytes)
              mem_a <= base + {29'b0, cnt + 3'd1};
            cnt <= cnt + 3'd1;
          end
        end
        WRITE: begin
          // cnt is the next byte to launch; cnt==nbytes means the last byte is on the bus.
          if (cnt == nbytes) begin
            mem_wr  <= 1'b0;
            ls_done <= 1'b1;
            state   <= DONE;
          end else if (stall_now) begin
            mem_wr <= 1'b0;
          end else begin
            mem_a    <= base + {29'b0, cnt};
            mem_dout <= wdata_q[{cnt[1:0], 3'b000} +: 8];
            mem_wr   <= 1'b1;
            cnt      <= cnt + 3'd1;
          end
        end
        default: begin
          ic_done <= 1'b0;
          ls_done <= 1'b0;
          mem_wr  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter_seq.sv
// tb/tb_mem_arbiter_seq.sv - self-checking bench for mem_arbiter_seq.
module tb_mem_arbiter_seq;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        ic_req = 1'b0;
  logic [31:0] ic_addr = '0;
  logic        ic_done;
  logic [31:0] ic_data;
  logic        ls_req = 1'b0;
  logic        ls_rw = 1'b0;
  logic [1:0]  ls_width = '0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic [7:0]  mem_din = '0;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic        io_buffer_full = 1'b0;

  mem_arbiter_seq #(.STARVE_LIMIT(4), .IO_SEL(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .ls_req(ls_req), .ls_rw(ls_rw), .ls_width(ls_width), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_din(mem_din), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0]  mem [logic [31:0]];
  logic [39:0] wq [$];

  always @(posedge clk_in) begin
    if (mem_wr) begin
      mem[mem_a] = mem_dout;
      wq.push_back({mem_a, mem_dout});
    end
    mem_din <= mem.exists(mem_a) ? mem[mem_a] : 8'h00;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t tv [10];

  task automatic do_ls(input logic rw, input logic [1:0] w, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output int lat);
    logic seen;
    @(negedge clk_in);
    ls_rw = rw; ls_width = w; ls_addr = a; ls_wdata = d; ls_req = 1'b1;
    lat = 0; rd = '0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk_in);
      lat++;
      if (ls_done) begin
        rd = ls_rdata;
        seen = 1'b1;
      end
    end
    ls_req = 1'b0;
    if (!seen) lat = -1;
  endtask

  logic [31:0] trace [0:15];

  task automatic do_ic(input logic [31:0] a, output logic [31:0] rd, output int lat);
    logic seen;
    @(negedge clk_in);
    ic_addr = a; ic_req = 1'b1;
    lat = 0; rd = '0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk_in);
      lat++;
      if (lat < 16) trace[lat] = mem_a;
      if (ic_done) begin
        rd = ic_data;
        seen = 1'b1;
      end
    end
    ic_req = 1'b0;
    if (!seen) lat = -1;
  endtask

  logic [31:0] rd;
  int          lat;
  int          hi;
  int          n;
  int          cyc;
  int          gseq [10];
  logic        seen;
  int          exp_io_lat;

  initial begin
    mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h50; mem[32'h103] = 8'h00;
    mem[32'h7]   = 8'h80;

    tv[0] = '{1'b1, 2'd1, 32'h0000_2002, 32'hDEAD_BEEF, 32'h0,         3};
    tv[1] = '{1'b0, 2'd1, 32'h0000_2002, 32'h0,         32'h0000_BEEF, 4};
    tv[2] = '{1'b1, 2'd2, 32'h0000_4000, 32'h1122_3344, 32'h0,         5};
    tv[3] = '{1'b0, 2'd2, 32'h0000_4000, 32'h0,         32'h1122_3344, 6};
    tv[4] = '{1'b0, 2'd0, 32'h0000_4003, 32'h0,         32'h0000_0011, 3};
    tv[5] = '{1'b0, 2'd1, 32'h0000_4001, 32'h0,         32'h0000_2233, 4};
    tv[6] = '{1'b1, 2'd3, 32'hFFFF_FFFE, 32'hA1B2_C3D4, 32'h0,         5};
    tv[7] = '{1'b0, 2'd1, 32'h0000_0000, 32'h0,         32'h0000_A1B2, 4};
    tv[8] = '{1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0,         32'h0000_00C3, 3};
    tv[9] = '{1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hA1B2_C3D4, 6};

    #1;
    chk("reset_outputs", {7'b0, ic_done, ls_done, mem_wr, mem_dout, mem_a[21:0]}, 40'h0);
    chk("reset_data", {8'h0, ic_data ^ ls_rdata}, 40'h0);
    @(negedge clk_in);
    rst_in = 1'b0;

    // iCache word fetch: address trace and assembly
    do_ic(32'h100, rd, lat);
    chk("ic_lat", 40'(lat), 40'd6);
    chk("ic_data", {8'h0, rd}, {8'h0, 32'h0050_0513});
    for (int i = 0; i < 4; i++)
      chk($sformatf("ic_mem_a_%0d", i), {8'h0, trace[i+1]}, {8'h0, 32'h100 + 32'(i)});

    // Half-word write bus trace
    wq.delete();
    do_ls(1'b1, 2'd1, 32'h2002, 32'hDEAD_BEEF, rd, lat);
    chk("wr_lat", 40'(lat), 40'd3);
    chk("wr_count", 40'(wq.size()), 40'd2);
    if (wq.size() == 2) begin
      chk("wr_byte0", wq[0], {32'h2002, 8'hEF});
      chk("wr_byte1", wq[1], {32'h2003, 8'hBE});
    end
    @(negedge clk_in);
    chk("wr_idle", 40'(mem_wr), 40'd0);

    for (int i = 0; i < 10; i++) begin
      do_ls(tv[i].rw, tv[i].w, tv[i].a, tv[i].d, rd, lat);
      chk($sformatf("vec%0d_lat", i), 40'(lat), 40'(tv[i].exp_lat));
      if (!tv[i].rw)
        chk($sformatf("vec%0d_rdata", i), {8'h0, rd}, {8'h0, tv[i].exp_rd});
    end

    // Freeze for two cycles mid-read
    @(negedge clk_in);
    ls_rw = 1'b0; ls_width = 2'd0; ls_addr = 32'h7; ls_req = 1'b1;
    lat = 0; seen = 1'b0; rd = '0;
    while (!seen && lat < 60) begin
      @(negedge clk_in);
      lat++;
      if (lat == 1) rdy_in = 1'b0;
      if (lat == 3) rdy_in = 1'b1;
      if (ls_done) begin seen = 1'b1; rd = ls_rdata; end
    end
    ls_req = 1'b0;
    rdy_in = 1'b1;
    chk("frz_lat", 40'(lat), 40'd5);
    chk("frz_rdata", {8'h0, rd}, {8'h0, 32'h80});

    // Done pulse held across a freeze
    do_ls(1'b0, 2'd0, 32'h7, 32'h0, rd, lat);
    rdy_in = 1'b0;
    hi = 1;
    @(negedge clk_in);
    if (ls_done) hi++;
    @(negedge clk_in);
    if (ls_done) hi++;
    rdy_in = 1'b1;
    @(negedge clk_in);
    chk("done_hold", 40'(hi), 40'd3);
    chk("done_clear", 40'(ls_done), 40'd0);

    // Anti-starvation: both requesters held
    for (int i = 0; i < 10; i++) gseq[i] = 2;
    ls_rw = 1'b0; ls_width = 2'd0; ls_addr = 32'h7; ic_addr = 32'h100;
    n = 0; cyc = 0;
    @(negedge clk_in);
    ic_req = 1'b1; ls_req = 1'b1;
    while (n < 10 && cyc < 500) begin
      @(negedge clk_in);
      cyc++;
      ic_req = 1'b1; ls_req = 1'b1;
      if (ls_done) begin gseq[n] = 0; n++; ls_req = 1'b0; end
      if (ic_done && n < 10) begin gseq[n] = 1; n++; ic_req = 1'b0; end
    end
    ic_req = 1'b0; ls_req = 1'b0;
    for (int i = 0; i < 10; i++)
      chk($sformatf("grant_%0d", i), 40'(gseq[i]), (i == 4 || i == 9) ? 40'd1 : 40'd0);

    // IO write with a full FIFO before byte 0
`ifdef MEMARB_IO_STALL_EN
    exp_io_lat = 8;
`else
    exp_io_lat = 5;
`endif
    @(negedge clk_in);
    wq.delete();
    ls_rw = 1'b1; ls_width = 2'd2; ls_addr = 32'h3_0000; ls_wdata = 32'hCAFE_F00D;
    ls_req = 1'b1; io_buffer_full = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk_in);
      lat++;
      if (lat == 3) io_buffer_full = 1'b0;
      if (ls_done) seen = 1'b1;
    end
    ls_req = 1'b0; io_buffer_full = 1'b0;
    chk("io_lat", 40'(lat), 40'(exp_io_lat));
    chk("io_count", 40'(wq.size()), 40'd4);
    if (wq.size() == 4) begin
      chk("io_byte0", wq[0], {32'h3_0000, 8'h0D});
      chk("io_byte3", wq[3], {32'h3_0003, 8'hCA});
    end

    // Async reset in the middle of a word fetch
    @(negedge clk_in);
    ic_addr = 32'h100; ic_req = 1'b1;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1; ic_req = 1'b0;
    #1;
    chk("rst_ctl", {37'b0, ic_done, ls_done, mem_wr}, 40'h0);
    chk("rst_mem_a", {8'h0, mem_a}, 40'h0);
    chk("rst_ic_data", {8'h0, ic_data}, 40'h0);
    chk("rst_ls_rdata", {8'h0, ls_rdata}, 40'h0);
    @(negedge clk_in);
    rst_in = 1'b0;
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_in);
      if (ic_done || ls_done) hi++;
    end
    chk("rst_no_done", 40'(hi), 40'd0);
    do_ic(32'h100, rd, lat);
    chk("rst_after_lat", 40'(lat), 40'd6);
    chk("rst_after_data", {8'h0, rd}, {8'h0, 32'h0050_0513});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
